product_accumulator: RTL and testbench
======================================

// Module: product_accumulator
// PURPOSE
//  Sequential consumer stage placed directly downstream of the 4x4 array multiplier.
//  Takes the 8-bit product R through a valid/ready handshake and sums N_TERMS
//  consecutive products into a registered accumulator (dot-product / MAC use).
//  Reports completion with a one-cycle done pulse and flags overflow.
// PARAMETERS
//  N_TERMS  4   products summed per run; legal range >=1, <=255
//  ACC_W    12  accumulator width; >=8. The default holds 4*225=900 without overflow.
// PORTS
//  clk         in   1      single clock; all state updates on the rising edge
//  rst         in   1      synchronous, active-high reset
//  start       in   1      begin a new run; sampled only in IDLE
//  prod_in     in   8      unsigned product from the multiplier R output
//  prod_valid  in   1      prod_in valid this cycle
//  prod_ready  out  1      block accepts prod_in this cycle
//  acc_out     out  ACC_W  running/final sum; registered
//  term_cnt    out  8      products accepted in the current run
//  busy        out  1      high in ACCUM
//  done        out  1      one-cycle pulse when the run completes
//  ovf         out  1      sticky overflow for the current run
// BEHAVIOUR
//  Reset: rst=1 at a clock edge forces the following, regardless of state:
//   - state=IDLE
//   - acc_out=0, term_cnt=0, busy=0, done=0, prod_ready=0, ovf=0
//  All outputs are registered or decoded from state; no comb path from input to output.
//  FSM:
//   - IDLE:  prod_ready=0. start=1 -> clear acc_out, term_cnt, ovf; next state ACCUM.
//   - ACCUM: busy=1, prod_ready=1. A transfer occurs when prod_valid & prod_ready:
//     acc_out <= acc_out + {0,prod_in}; term_cnt <= term_cnt+1.
//     A transfer with term_cnt==N_TERMS-1 -> next state DONE.
//   - DONE:  busy=0, prod_ready=0, done=1 for exactly this one cycle; next state IDLE.
//  Latency: done rises 1 cycle after the final transfer edge. The final sum is on
//  acc_out in that same cycle.
//  Result hold: acc_out, term_cnt and ovf hold in IDLE until the next start or rst.
//  start is ignored in ACCUM and DONE; it is not queued.
//  prod_valid is ignored outside ACCUM. Idle cycles (prod_valid=0) do not change state.
//  N_TERMS=1: one transfer goes ACCUM->DONE.
//  Width rule: prod_in is zero-extended to ACC_W. The sum is computed at ACC_W+1 bits.
//  If the carry bit is set, ovf <= 1 (sticky until next start/rst), handled per CONFIGURATION.
//  Reset mid-run: immediate return to IDLE with cleared outputs. No done pulse.
// CONFIGURATION
//  ACC_SATURATE_EN defined:
//   - overflowing add clamps acc_out to 2^ACC_W-1
//   - later adds keep it clamped
//   - ovf=1
//  ACC_SATURATE_EN undefined:
//   - sum wraps modulo 2^ACC_W
//   - ovf=1
// TESTING
//  T1 reset: rst=1 for 2 cycles in any state -> acc_out=0, term_cnt=0, busy=0, done=0,
//     prod_ready=0, ovf=0.
//  T2 basic run, defaults: start; stream 225,30,0,1 back-to-back -> acc_out=256,
//     term_cnt=4, done high for exactly 1 cycle, ovf=0, return to IDLE.
//  T3 gaps: same 4 products with prod_valid low 1-3 cycles between them -> same result,
//     256; only valid&ready cycles counted.
//  T4 overflow, ACC_W=8, N_TERMS=2: 200,100 -> wrap build: acc_out=44, ovf=1;
//     ACC_SATURATE_EN build: acc_out=255, ovf=1.
//  T5 rst mid-run after 2 of 4 transfers -> IDLE, acc_out=0, no done;
//     a new start+4 products works normally.
//  T6 start pulsed during ACCUM and DONE -> ignored. A start in the IDLE cycle that
//     follows clears acc_out and ovf and begins a new run.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: valid/ready consumer that sums N_TERMS consecutive
// unsigned 8-bit products into a registered ACC_W-bit accumulator.
// Reports completion with a one-cycle done pulse and a sticky overflow flag.
// Optional feature: define ACC_SATURATE_EN to clamp the sum at 2^ACC_W-1 on
// overflow; by default the sum wraps modulo 2^ACC_W.
module product_accumulator #(
    parameter int unsigned N_TERMS = 4,
    parameter int unsigned ACC_W   = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [7:0]       term_cnt,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q,   acc_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               ovf_q,   ovf_d;
    logic               busy_q,  busy_d;
    logic               ready_q, ready_d;
    logic               done_q,  done_d;

    logic               xfer;
    logic [SUM_W-1:0]   sum;
    logic               carry;

    // Extended-width sum so the carry out of the accumulator is visible.
    always_comb begin
        xfer  = prod_valid & ready_q;
        sum   = SUM_W'(acc_q) + SUM_W'(prod_in);
        carry = sum[ACC_W];
    end

    // Next-state, datapath and flag-decode logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
`ifdef ACC_SATURATE_EN
                    acc_d = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
                    acc_d = sum[ACC_W-1:0];
`endif
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the next-state decode so they
        // line up exactly with the state they describe.
        busy_d  = (state_d == ACCUM);
        ready_d = (state_d == ACCUM);
        done_d  = (state_d == DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign prod_ready = ready_q;
    assign acc_out    = acc_q;
    assign term_cnt   = cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed testbench for product_accumulator: a default instance (N_TERMS=4,
// ACC_W=12) and a narrow instance (N_TERMS=2, ACC_W=8) for overflow behaviour.
// Overflow expectations follow ACC_SATURATE_EN.
module tb_product_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    // Default instance signals
    logic        start;
    logic [7:0]  prod_in;
    logic        prod_valid;
    logic        prod_ready;
    logic [11:0] acc_out;
    logic [7:0]  term_cnt;
    logic        busy;
    logic        done;
    logic        ovf;

    // Narrow instance signals
    logic        start2;
    logic [7:0]  prod_in2;
    logic        prod_valid2;
    logic        prod_ready2;
    logic [7:0]  acc_out2;
    logic [7:0]  term_cnt2;
    logic        busy2;
    logic        done2;
    logic        ovf2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    product_accumulator #(.N_TERMS(4), .ACC_W(12)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .acc_out    (acc_out),
        .term_cnt   (term_cnt),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    product_accumulator #(.N_TERMS(2), .ACC_W(8)) u_narrow (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .prod_in    (prod_in2),
        .prod_valid (prod_valid2),
        .prod_ready (prod_ready2),
        .acc_out    (acc_out2),
        .term_cnt   (term_cnt2),
        .busy       (busy2),
        .done       (done2),
        .ovf        (ovf2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one product on the default instance after 'gap' idle cycles.
    task automatic send(input logic [7:0] p, input int gap);
        repeat (gap) begin
            prod_valid = 1'b0;
            prod_in    = 8'hAA;
            tick();
        end
        prod_valid = 1'b1;
        prod_in    = p;
        tick();
        prod_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] p);
        prod_valid2 = 1'b1;
        prod_in2    = p;
        tick();
        prod_valid2 = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_acc"},   32'(acc_out),    32'd0);
        check({tag, "_cnt"},   32'(term_cnt),   32'd0);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_ready"}, 32'(prod_ready), 32'd0);
        check({tag, "_ovf"},   32'(ovf),        32'd0);
    endtask

    task automatic begin_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_wrap;

        rst = 1'b1; start = 1'b0; prod_in = '0; prod_valid = 1'b0;
        start2 = 1'b0; prod_in2 = '0; prod_valid2 = 1'b0;

        // T1: reset held two cycles
        tick(); tick();
        check_cleared("t1_reset");
        check("t1_narrow_ready", 32'(prod_ready2), 32'd0);
        rst = 1'b0;
        tick();

        // T2: back-to-back run 225,30,0,1 -> 256
        begin_run();
        check("t2_busy",  32'(busy),       32'd1);
        check("t2_ready", 32'(prod_ready), 32'd1);
        check("t2_cnt0",  32'(term_cnt),   32'd0);
        send(8'd225, 0);
        send(8'd30,  0);
        send(8'd0,   0);
        check("t2_acc3",  32'(acc_out),  32'd255);
        check("t2_cnt3",  32'(term_cnt), 32'd3);
        check("t2_done3", 32'(done),     32'd0);
        send(8'd1,   0);
        check("t2_done",  32'(done),       32'd1);
        check("t2_acc",   32'(acc_out),    32'd256);
        check("t2_cnt",   32'(term_cnt),   32'd4);
        check("t2_busy_d",32'(busy),       32'd0);
        check("t2_rdy_d", 32'(prod_ready), 32'd0);
        check("t2_ovf",   32'(ovf),        32'd0);
        prod_valid = 1'b1; prod_in = 8'd50;   // ignored in DONE and IDLE
        tick();
        check("t2_done_pulse", 32'(done),     32'd0);
        check("t2_idle_busy",  32'(busy),     32'd0);
        tick();
        prod_valid = 1'b0;
        check("t2_hold_acc",   32'(acc_out),  32'd256);
        check("t2_hold_cnt",   32'(term_cnt), 32'd4);

        // T3: same products with gaps
        begin_run();
        check("t3_clear_acc", 32'(acc_out), 32'd0);
        send(8'd225, 1);
        send(8'd30,  2);
        check("t3_cnt2", 32'(term_cnt), 32'd2);
        prod_in = 8'd99; tick();              // valid low: no transfer
        check("t3_gap_cnt", 32'(term_cnt), 32'd2);
        check("t3_gap_acc", 32'(acc_out),  32'd255);
        send(8'd0, 2);
        send(8'd1, 1);
        check("t3_done", 32'(done),     32'd1);
        check("t3_acc",  32'(acc_out),  32'd256);
        check("t3_cnt",  32'(term_cnt), 32'd4);
        tick();

        // T4: overflow on the narrow instance, 200+100
`ifdef ACC_SATURATE_EN
        exp_wrap = 32'd255;
`else
        exp_wrap = 32'd44;
`endif
        start2 = 1'b1; tick(); start2 = 1'b0;
        check("t4_busy", 32'(busy2), 32'd1);
        send2(8'd200);
        check("t4_acc1", 32'(acc_out2), 32'd200);
        check("t4_ovf1", 32'(ovf2),     32'd0);
        send2(8'd100);
        check("t4_done", 32'(done2),    32'd1);
        check("t4_acc",  32'(acc_out2), exp_wrap);
        check("t4_ovf",  32'(ovf2),     32'd1);
        check("t4_cnt",  32'(term_cnt2),32'd2);
        tick();
        check("t4_hold_ovf", 32'(ovf2),     32'd1);
        check("t4_hold_acc", 32'(acc_out2), exp_wrap);
        start2 = 1'b1; tick(); start2 = 1'b0;
        check("t4_clr_ovf", 32'(ovf2),     32'd0);
        check("t4_clr_acc", 32'(acc_out2), 32'd0);
        send2(8'd3);
        send2(8'd4);
        check("t4_small_acc", 32'(acc_out2), 32'd7);
        check("t4_small_ovf", 32'(ovf2),     32'd0);
        tick();

        // T5: reset after 2 of 4 transfers, then a normal run
        begin_run();
        send(8'd225, 0);
        send(8'd30,  0);
        check("t5_cnt2", 32'(term_cnt), 32'd2);
        rst = 1'b1; tick();
        check_cleared("t5_rst");
        rst = 1'b0; tick();
        check("t5_no_done", 32'(done), 32'd0);
        check("t5_idle",    32'(busy), 32'd0);
        begin_run();
        send(8'd10, 0);
        send(8'd20, 0);
        send(8'd30, 0);
        send(8'd40, 0);
        check("t5_done", 32'(done),    32'd1);
        check("t5_acc",  32'(acc_out), 32'd100);
        tick();

        // T6: start held through ACCUM and DONE is ignored
        begin_run();
        start = 1'b1;
        send(8'd1, 0);
        send(8'd2, 0);
        check("t6_cnt_mid", 32'(term_cnt), 32'd2);
        send(8'd3, 0);
        send(8'd4, 0);
        check("t6_done", 32'(done),    32'd1);
        check("t6_acc",  32'(acc_out), 32'd10);
        tick();                               // DONE -> IDLE, start not sampled
        check("t6_idle_busy", 32'(busy),     32'd0);
        check("t6_idle_acc",  32'(acc_out),  32'd10);
        check("t6_idle_done", 32'(done),     32'd0);
        tick();                               // start seen in IDLE
        start = 1'b0;
        check("t6_new_busy", 32'(busy),     32'd1);
        check("t6_new_acc",  32'(acc_out),  32'd0);
        check("t6_new_cnt",  32'(term_cnt), 32'd0);
        send(8'd255, 0);
        send(8'd255, 0);
        send(8'd255, 0);
        send(8'd255, 0);
        check("t6_max_acc", 32'(acc_out), 32'd1020);
        check("t6_max_ovf", 32'(ovf),     32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
